wshb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone arbiter sitting between the SDRAM slave port and two masters: m0 is the pattern/image writer and m1 is the vga frame reader.
- The vga reader holds cyc high whenever its FIFO is not full. Without intervention it would starve m0.
- The arbiter therefore alternates ownership round-robin and forcibly preempts an owner after MAX_ACKS transfers when the other master is waiting.
- Classic (non-burst) cycles only. cti/bte are not routed.

---
 rtl/wshb_arbiter2.sv | 137 +++++++++++++
 tb/tb_wshb_arbiter2.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter2.sv
// Two-master, one-slave classic Wishbone arbiter with round-robin ownership
// and forced preemption of an owner after MAX_ACKS acks while the other waits.
module wshb_arbiter2 #(
  parameter int unsigned MAX_ACKS = 64,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [3:0]    m0_sel,
  input  logic [AW-1:0] m0_adr,
  input  logic [31:0]   m0_dat_ms,
  output logic [31:0]   m0_dat_sm,
  output logic          m0_ack,

  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [3:0]    m1_sel,
  input  logic [AW-1:0] m1_adr,
  input  logic [31:0]   m1_dat_ms,
  output logic [31:0]   m1_dat_sm,
  output logic          m1_ack,

  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [3:0]    s_sel,
  output logic [AW-1:0] s_adr,
  output logic [31:0]   s_dat_ms,
  input  logic [31:0]   s_dat_sm,
  input  logic          s_ack,

  output logic [1:0]    grant
);

  localparam int unsigned CW = $clog2(MAX_ACKS + 1);
  localparam logic [CW-1:0] AcntMax  = CW'(MAX_ACKS);
  localparam logic [CW-1:0] AcntLast = CW'(MAX_ACKS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant0,
    StGrant1,
    StPreempt
  } state_e;

  state_e          r_state, w_state_d;
  logic            r_last, w_last_d;
  logic [CW-1:0]   r_acnt, w_acnt_d;

  logic            w_granted;
  logic            w_sel_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
      r_acnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
      r_acnt  <= w_acnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_last_d  = r_last;
    w_acnt_d  = r_acnt;

    unique case (r_state)
      StIdle: begin
        if (m0_cyc && (!m1_cyc || r_last)) begin
          w_state_d = StGrant0;
        end else if (m1_cyc) begin
          w_state_d = StGrant1;
        end
      end
      StGrant0: begin
        if (!m0_cyc) begin
          w_state_d = StIdle;
        end else if (s_ack) begin
          if (r_acnt != AcntMax) w_acnt_d = r_acnt + 1'b1;
          // >= so a counter that saturated while m1 was idle still yields once m1 asks
          if (m1_cyc && (r_acnt >= AcntLast)) w_state_d = StPreempt;
        end
      end
      StGrant1: begin
        if (!m1_cyc) begin
          w_state_d = StIdle;
        end else if (s_ack) begin
          if (r_acnt != AcntMax) w_acnt_d = r_acnt + 1'b1;
          if (m0_cyc && (r_acnt >= AcntLast)) w_state_d = StPreempt;
        end
      end
      StPreempt: begin
        if (r_last ? m0_cyc : m1_cyc) begin
          w_state_d = r_last ? StGrant0 : StGrant1;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_state_d == StGrant0 && r_state != StGrant0) begin
      w_last_d = 1'b0;
      w_acnt_d = '0;
    end else if (w_state_d == StGrant1 && r_state != StGrant1) begin
      w_last_d = 1'b1;
      w_acnt_d = '0;
    end
  end

  assign w_granted = (r_state == StGrant0) || (r_state == StGrant1);
  // Outside a grant the data path parks on the last owner to avoid toggling.
  assign w_sel_m1  = w_granted ? (r_state == StGrant1) : r_last;

  assign s_cyc     = w_granted && (w_sel_m1 ? m1_cyc : m0_cyc);
  assign s_stb     = w_granted && (w_sel_m1 ? m1_stb : m0_stb);
  assign s_we      = w_sel_m1 ? m1_we     : m0_we;
  assign s_sel     = w_sel_m1 ? m1_sel    : m0_sel;
  assign s_adr     = w_sel_m1 ? m1_adr    : m0_adr;
  assign s_dat_ms  = w_sel_m1 ? m1_dat_ms : m0_dat_ms;

  assign m0_ack    = (r_state == StGrant0) && s_ack;
  assign m1_ack    = (r_state == StGrant1) && s_ack;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  assign grant     = {r_state == StGrant1, r_state == StGrant0};

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Randomized bench for wshb_arbiter2 against an ownership-level reference model.
module tb_wshb_arbiter2;

  localparam int unsigned MaxAcks = 5;
  localparam int unsigned AW      = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]    m0_sel = 0;
  logic [AW-1:0] m0_adr = 0;
  logic [31:0]   m0_dat_ms = 0, m0_dat_sm;
  logic          m0_ack;
  logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]    m1_sel = 0;
  logic [AW-1:0] m1_adr = 0;
  logic [31:0]   m1_dat_ms = 0, m1_dat_sm;
  logic          m1_ack;
  logic          s_cyc, s_stb, s_we;
  logic [3:0]    s_sel;
  logic [AW-1:0] s_adr;
  logic [31:0]   s_dat_ms;
  logic [31:0]   s_dat_sm = 0;
  logic          s_ack = 0;
  logic [1:0]    grant;

  wshb_arbiter2 #(.MAX_ACKS(MaxAcks), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm), .s_ack(s_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether we are in the one-cycle
  // yield gap, who owned last, and how many acks the owner has had.
  int owner   = -1;
  bit yielding = 0;
  int last    = 1;
  int acks    = 0;

  task automatic model_reset();
    owner = -1; yielding = 0; last = 1; acks = 0;
  endtask

  task automatic take(input int n);
    owner = n; last = n; acks = 0;
  endtask

  task automatic model_update();
    bit c[2];
    c[0] = m0_cyc; c[1] = m1_cyc;
    if (rst) begin
      model_reset();
    end else if (yielding) begin
      yielding = 0;
      if (c[1-last]) take(1 - last);
      else owner = -1;
    end else if (owner < 0) begin
      if (c[0] && c[1]) take(1 - last);
      else if (c[0]) take(0);
      else if (c[1]) take(1);
    end else if (!c[owner]) begin
      owner = -1;
    end else if (s_ack) begin
      if (c[1-owner] && acks + 1 >= MaxAcks) begin
        owner = -1;
        yielding = 1;
      end
      acks = (acks + 1 > MaxAcks) ? MaxAcks : acks + 1;
    end
  endtask

  task automatic check_outputs();
    int  sel;
    logic cyc_o, stb_o;
    sel   = (owner >= 0) ? owner : last;
    cyc_o = (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
    stb_o = (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
    check("grant",    64'(grant),    (owner == 0) ? 64'd1 : (owner == 1) ? 64'd2 : 64'd0);
    check("s_cyc",    64'(s_cyc),    64'(cyc_o));
    check("s_stb",    64'(s_stb),    64'(stb_o));
    check("s_we",     64'(s_we),     64'(sel ? m1_we : m0_we));
    check("s_sel",    64'(s_sel),    64'(sel ? m1_sel : m0_sel));
    check("s_adr",    64'(s_adr),    64'(sel ? m1_adr : m0_adr));
    check("s_dat_ms", 64'(s_dat_ms), 64'(sel ? m1_dat_ms : m0_dat_ms));
    check("m0_ack",   64'(m0_ack),   64'((owner == 0) && s_ack));
    check("m1_ack",   64'(m1_ack),   64'((owner == 1) && s_ack));
    check("m0_dat",   64'(m0_dat_sm), 64'(s_dat_sm));
    check("m1_dat",   64'(m1_dat_sm), 64'(s_dat_sm));
  endtask

  // Drive modes: 0 random, 1 forced high, 2 forced low.
  int mode0 = 2, mode1 = 2, mode_ack = 0;

  task automatic drive_master(input int mode, inout logic cyc);
    if (mode == 1)      cyc = 1'b1;
    else if (mode == 2) cyc = 1'b0;
    else if (cyc)       cyc = ($urandom_range(15) != 0);
    else                cyc = ($urandom_range(3) == 0);
  endtask

  task automatic drive_inputs();
    logic c0, c1;
    c0 = m0_cyc; c1 = m1_cyc;
    drive_master(mode0, c0);
    drive_master(mode1, c1);
    m0_cyc = c0; m1_cyc = c1;
    m0_stb = c0 && ($urandom_range(3) != 0);
    m1_stb = c1 && ($urandom_range(3) != 0);
    m0_we = 1'($urandom); m1_we = 1'($urandom);
    m0_sel = 4'($urandom); m1_sel = 4'($urandom);
    m0_adr = AW'($urandom); m1_adr = AW'($urandom);
    m0_dat_ms = $urandom; m1_dat_ms = $urandom; s_dat_sm = $urandom;
    s_ack = (mode_ack == 1) ? 1'b1 : (mode_ack == 2) ? 1'b0 : 1'($urandom);
  endtask

  bit count_runs = 0;
  bit seen_gap   = 0;
  int run        = 0;

  task automatic step();
    @(negedge clk);
    drive_inputs();
    #1;
    check_outputs();
    if (count_runs) begin
      run += int'(m0_ack) + int'(m1_ack);
      if (grant == 2'b00 && !s_cyc) begin
        if (seen_gap) check("run_len", 64'(run), 64'(MaxAcks));
        seen_gap = 1;
        run = 0;
      end
    end
    @(posedge clk);
    model_update();
  endtask

  initial begin
    // Reset state with a stray ack present.
    mode_ack = 1;
    #12;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_scyc",  64'(s_cyc), 64'd0);
    check("rst_ack",   64'({m0_ack, m1_ack}), 64'd0);
    repeat (2) step();
    #2 rst = 1'b0;

    // Both request together: m0 wins the first tie.
    mode0 = 1; mode1 = 1;
    repeat (3) step();
    mode0 = 2; mode1 = 2;
    repeat (3) step();

    // m0 alone, slave acks every cycle.
    mode0 = 1;
    repeat (10) step();
    mode0 = 2;
    repeat (2) step();

    // Spurious ack while idle.
    mode_ack = 1;
    repeat (3) step();

    // Both hold: alternation every MaxAcks acks with a one-cycle gap.
    mode0 = 1; mode1 = 1; count_runs = 1; seen_gap = 0; run = 0;
    repeat (8 * (MaxAcks + 1) + 4) step();
    count_runs = 0;

    // m1 alone for many acks: saturating counter, no preemption.
    mode0 = 2; mode1 = 1;
    repeat (500) step();
    // m0 arrives late; m1 must still yield after its saturated run.
    mode0 = 1;
    repeat (20) step();
    mode0 = 2; mode1 = 2;
    repeat (3) step();

    // Fully random traffic.
    mode0 = 0; mode1 = 0; mode_ack = 0;
    repeat (3000) step();

    // Asynchronous reset in the middle of an m1 grant.
    mode0 = 2; mode1 = 1; mode_ack = 1;
    for (int i = 0; i < 20 && owner != 1; i++) step();
    step();
    check("wait_g1", 64'(grant), 64'd2);
    #3 rst = 1'b1;
    #1;
    check("arst_scyc",  64'(s_cyc),  64'd0);
    check("arst_grant", 64'(grant),  64'd0);
    check("arst_ack",   64'(m1_ack), 64'd0);
    model_reset();
    repeat (2) step();
    #2 rst = 1'b0;
    mode0 = 1; mode1 = 1;
    repeat (3) step();
    check("post_rst_g0", 64'(grant), 64'd1);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
